// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter slice: FSM state encoding
// and constant-width helpers used by the arbiter, its interface and the FIFO.
package fifo_wr_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // An index into a set of n items never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side and FIFO-side signals of the write arbiter.
// The arbiter takes the slave view; the requesters/FIFO environment the master view.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  import fifo_wr_arbiter_pkg::*;

  localparam int IW = idx_width(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   fifo_full;
  logic                   fifo_pop;
  logic                   fifo_wr_en;
  logic [WIDTH-1:0]       fifo_din;
  logic [IW-1:0]          grant_id;
  logic                   busy;

  modport master (
    output req_valid, req_data, fifo_full, fifo_pop,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full, fifo_pop,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Wrap-around priority search: returns the first set bit of req at or above
// ptr, wrapping back through index 0. Purely combinational.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [N-1:0] rot_s;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    return (sum >= N) ? IW'(sum - N) : IW'(sum);
  endfunction

  // Rotate so that bit 0 of rot_s corresponds to requester ptr.
  assign rot_s = N'({req, req} >> ptr);

  // Descending scan: the lowest rotated offset with a request wins.
  always_comb begin
    idx   = {IW{1'b0}};
    found = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx = rot_s[k] ? wrap_idx(ptr, k) : idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time for up to BURST
// beats, forwards its data to a downstream FIFO and tracks FIFO occupancy.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int BURST = 4
) (
  input logic              clk,
  input logic              reset,
  fifo_wr_arbiter_if.slave bus
);

  localparam int IW = idx_width(N_REQ);
  localparam int OW = clog2(DEPTH + 1);
  localparam int BW = clog2(BURST + 1);
  localparam logic [OW-1:0] DEPTH_C   = OW'(DEPTH);
  localparam logic [BW-1:0] BURST_C   = BW'(BURST);
  localparam logic [IW-1:0] LAST_ID_C = IW'(N_REQ - 1);

  arb_state_t       state_r, state_nxt_s;
  logic [IW-1:0]    rr_ptr_r, rr_ptr_nxt_s;
  logic [IW-1:0]    grant_id_r, grant_id_nxt_s;
  logic [IW-1:0]    pick_idx_s, ptr_inc_s;
  logic [BW-1:0]    beat_cnt_r, beat_cnt_nxt_s;
  logic [OW-1:0]    occ_r, occ_nxt_s;
  logic [WIDTH-1:0] fifo_din_r, gnt_data_s;
  logic             fifo_wr_en_r;
  logic             pick_found_s, space_s, gnt_valid_s, xfer_s, pop_eff_s, burst_done_s;
  logic [N_REQ-1:0] req_ready_s;

  rr_pick #(.N(N_REQ), .IW(IW)) u_rr_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  assign space_s      = (occ_r < DEPTH_C) && !bus.fifo_full;
  assign gnt_valid_s  = bus.req_valid[grant_id_r];
  assign gnt_data_s   = bus.req_data[int'(grant_id_r) * WIDTH +: WIDTH];
  assign xfer_s       = (state_r == GRANT) && gnt_valid_s && space_s;
  assign pop_eff_s    = bus.fifo_pop && (occ_r != {OW{1'b0}});
  assign burst_done_s = (beat_cnt_r + BW'(1)) == BURST_C;
  assign ptr_inc_s    = (grant_id_r == LAST_ID_C) ? {IW{1'b0}} : grant_id_r + IW'(1);

  // Only the current grantee sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      req_ready_s[i] = (state_r == GRANT) && (grant_id_r == IW'(i)) && space_s;
    end
  end

  // Arbitration FSM next-state: a stalled grant (valid but no space) holds.
  always_comb begin
    state_nxt_s    = state_r;
    grant_id_nxt_s = grant_id_r;
    beat_cnt_nxt_s = beat_cnt_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_nxt_s    = GRANT;
          grant_id_nxt_s = pick_idx_s;
          beat_cnt_nxt_s = {BW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        if (!gnt_valid_s || (xfer_s && burst_done_s)) begin
          state_nxt_s    = IDLE;
          rr_ptr_nxt_s   = ptr_inc_s;
          beat_cnt_nxt_s = xfer_s ? beat_cnt_r + BW'(1) : beat_cnt_r;
        end else if (xfer_s) begin
          beat_cnt_nxt_s = beat_cnt_r + BW'(1);
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Occupancy: a pop and a transfer in the same cycle cancel out.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({xfer_s, pop_eff_s})
      2'b10:   occ_nxt_s = occ_r + OW'(1);
      2'b01:   occ_nxt_s = occ_r - OW'(1);
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Arbitration state and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {IW{1'b0}};
      grant_id_r <= {IW{1'b0}};
      beat_cnt_r <= {BW{1'b0}};
      occ_r      <= {OW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      grant_id_r <= grant_id_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      occ_r      <= occ_nxt_s;
    end
  end

  // FIFO write port, one cycle behind the handshake; data holds between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wr_en_r <= 1'b0;
      fifo_din_r   <= {WIDTH{1'b0}};
    end else begin
      fifo_wr_en_r <= xfer_s;
      fifo_din_r   <= xfer_s ? gnt_data_s : fifo_din_r;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.fifo_wr_en = fifo_wr_en_r;
  assign bus.fifo_din   = fifo_din_r;
  assign bus.grant_id   = grant_id_r;
  assign bus.busy       = (state_r == GRANT);

endmodule
